// File: rtl/bcd_key_counter_pkg.sv
// Shared types and constants for the two-digit BCD key counter.
// Digit limits, key FSM encoding and a bit-order helper.
package bcd_key_counter_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t BCD_MAX  = 4'd9;
  localparam digit_t BCD_ZERO = 4'd0;

  typedef enum logic [1:0] {
    KEY_IDLE,
    KEY_ARMING,
    KEY_HELD,
    KEY_RELEASING
  } key_state_e;

  // Board vectors are ascending ranges with weight 1 leftmost.
  function automatic digit_t rev4(
    input logic [3:0] v
  );
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/bcd_key_counter_if.sv
// Board-side bundle of the key counter.
// Buttons, load switches and the two digit outputs.
interface bcd_key_counter_if;

  logic        V_KEY_UP;
  logic        V_KEY_DN;
  logic        V_SW_LOAD;
  logic [14:17] V_SW;
  logic [0:3]  G_BCD0;
  logic [0:3]  G_BCD1;
  logic        G_WRAP;

  modport master (
    output V_KEY_UP,
    output V_KEY_DN,
    output V_SW_LOAD,
    output V_SW,
    input  G_BCD0,
    input  G_BCD1,
    input  G_WRAP
  );

  modport slave (
    input  V_KEY_UP,
    input  V_KEY_DN,
    input  V_SW_LOAD,
    input  V_SW,
    output G_BCD0,
    output G_BCD1,
    output G_WRAP
  );

endinterface

// File: rtl/bcd_key_counter_key_debounce.sv
// Per-button synchroniser, debounce FSM and press pulse.
// One pulse per accepted press; release never pulses.
module key_debounce
  import bcd_key_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0]    sync_q;
  key_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          press_q;
  logic          lvl;

  assign lvl   = sync_q[1];
  assign press = press_q;

  // The entering sample already counts as the first one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= KEY_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n};
      press_q <= 1'b0;
      case (state_q)
        KEY_IDLE: begin
          if (!lvl) begin
            state_q <= KEY_ARMING;
            cnt_q   <= CNT_ONE;
          end
        end
        KEY_ARMING: begin
          if (lvl) begin
            state_q <= KEY_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= KEY_HELD;
            cnt_q   <= '0;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        KEY_HELD: begin
          if (lvl) begin
            state_q <= KEY_RELEASING;
            cnt_q   <= CNT_ONE;
          end
        end
        KEY_RELEASING: begin
          if (!lvl) begin
            state_q <= KEY_HELD;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= KEY_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= KEY_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bcd_key_counter.sv
// Two-digit BCD up/down counter driven by debounced keys.
// Load path, per-digit arithmetic and registered wrap pulse.
module bcd_key_counter
  import bcd_key_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic              V_CLOCK_50,
  input logic              V_RST_N,
  bcd_key_counter_if.slave bus
);

  logic [1:0] rst_q;
  logic       rst_n;
  logic       up_p;
  logic       dn_p;
  logic [1:0] ld_q;
  digit_t     sw_in;
  digit_t     sw_s1_q;
  digit_t     sw_s2_q;
  digit_t     ones_q, ones_d;
  digit_t     tens_q, tens_d;
  logic       wrap_q, wrap_d;

  // Async assert, release aligned to the clock.
  always_ff @(posedge V_CLOCK_50 or negedge V_RST_N) begin
    if (!V_RST_N) rst_q <= 2'b00;
    else          rst_q <= {rst_q[0], 1'b1};
  end

  assign rst_n = rst_q[1];

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_up (
    .clk  (V_CLOCK_50),
    .rst_n(rst_n),
    .key_n(bus.V_KEY_UP),
    .press(up_p)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dn (
    .clk  (V_CLOCK_50),
    .rst_n(rst_n),
    .key_n(bus.V_KEY_DN),
    .press(dn_p)
  );

  assign sw_in = rev4(bus.V_SW);

  always_ff @(posedge V_CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      ld_q    <= 2'b00;
      sw_s1_q <= BCD_ZERO;
      sw_s2_q <= BCD_ZERO;
    end else begin
      ld_q    <= {ld_q[0], bus.V_SW_LOAD};
      sw_s1_q <= sw_in;
      sw_s2_q <= sw_s1_q;
    end
  end

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    wrap_d = 1'b0;
    if (ld_q[1]) begin
      if (sw_s2_q <= BCD_MAX) begin
        ones_d = sw_s2_q;
        tens_d = BCD_ZERO;
      end
    end else if (up_p && dn_p) begin
      ones_d = ones_q;
    end else if (up_p) begin
      if (ones_q == BCD_MAX) begin
        ones_d = BCD_ZERO;
        if (tens_q == BCD_MAX) begin
          tens_d = BCD_ZERO;
          wrap_d = 1'b1;
        end else begin
          tens_d = tens_q + 4'd1;
        end
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (dn_p) begin
      if (ones_q == BCD_ZERO) begin
        ones_d = BCD_MAX;
        if (tens_q == BCD_ZERO) begin
          tens_d = BCD_MAX;
          wrap_d = 1'b1;
        end else begin
          tens_d = tens_q - 4'd1;
        end
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  always_ff @(posedge V_CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= BCD_ZERO;
      tens_q <= BCD_ZERO;
      wrap_q <= 1'b0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.G_BCD0 = rev4(ones_q);
  assign bus.G_BCD1 = rev4(tens_q);
  assign bus.G_WRAP = wrap_q;

endmodule

// File: tb/tb_bcd_key_counter.sv
// Bench for bcd_key_counter: directed table, corner sequences,
// random stimulus against a run-length debounce model.
module tb_bcd_key_counter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bcd_key_counter_if bus();

  bcd_key_counter #(
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .V_CLOCK_50(clk),
    .V_RST_N   (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int wrap_seen = 0;

  int         m_val;
  bit         m_wrap;
  bit         m_pu, m_pd;
  logic [6:0] m_h0, m_h1;
  int         m_run[2];
  bit         m_acc[2];
  int         m_hold;

  task automatic check(input string name,
                       input int act,
                       input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int dig(input logic [0:3] d);
    return int'({d[3], d[2], d[1], d[0]});
  endfunction

  function automatic int shown();
    return dig(bus.G_BCD1) * 10 + dig(bus.G_BCD0);
  endfunction

  task automatic set_sw(input logic [3:0] v);
    bus.V_SW[14] = v[0];
    bus.V_SW[15] = v[1];
    bus.V_SW[16] = v[2];
    bus.V_SW[17] = v[3];
  endtask

  task automatic model_reset();
    m_val  = 0;
    m_wrap = 0;
    m_pu   = 0;
    m_pd   = 0;
    m_h0   = 7'b1100000;
    m_h1   = 7'b1100000;
    m_run  = '{0, 0};
    m_acc  = '{1'b1, 1'b1};
  endtask

  // Accept a level once it differs from the accepted one for N samples.
  function automatic bit deb(input int k, input bit lvl);
    if (lvl == m_acc[k]) begin
      m_run[k] = 0;
      return 1'b0;
    end
    m_run[k]++;
    if (m_run[k] == N) begin
      m_acc[k] = lvl;
      m_run[k] = 0;
      return !lvl;
    end
    return 1'b0;
  endfunction

  task automatic model_edge();
    logic [6:0] seen;
    logic [3:0] sw;
    if (!rst_n) begin
      model_reset();
      m_hold = 2;
    end else if (m_hold > 0) begin
      model_reset();
      m_hold--;
    end else begin
      seen   = m_h1;
      sw     = seen[3:0];
      m_wrap = 0;
      if (seen[4]) begin
        if (sw <= 4'd9) m_val = int'(sw);
      end else if (m_pu && m_pd) begin
        m_wrap = 0;
      end else if (m_pu) begin
        m_wrap = (m_val == 99);
        m_val  = (m_val + 1) % 100;
      end else if (m_pd) begin
        m_wrap = (m_val == 0);
        m_val  = (m_val + 99) % 100;
      end
      m_pu = deb(0, seen[6]);
      m_pd = deb(1, seen[5]);
      m_h1 = m_h0;
      m_h0 = {bus.V_KEY_UP, bus.V_KEY_DN, bus.V_SW_LOAD,
              bus.V_SW[17], bus.V_SW[16],
              bus.V_SW[15], bus.V_SW[14]};
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("ones", dig(bus.G_BCD0), m_val % 10);
    check("tens", dig(bus.G_BCD1), m_val / 10);
    check("wrap", int'(bus.G_WRAP), int'(m_wrap));
    if (bus.G_WRAP) wrap_seen++;
  endtask

  task automatic drive(input bit up, input bit dn, input int n);
    bus.V_KEY_UP = up;
    bus.V_KEY_DN = dn;
    repeat (n) cycle();
  endtask

  task automatic async_reset(input string name);
    #3;
    rst_n = 1'b0;
    model_reset();
    m_hold = 2;
    #1;
    check({name, "_ones"}, dig(bus.G_BCD0), 0);
    check({name, "_tens"}, dig(bus.G_BCD1), 0);
    check({name, "_wrap"}, int'(bus.G_WRAP), 0);
  endtask

  typedef enum {OP_UP, OP_DN, OP_BOTH, OP_LOAD, OP_LOAD_UP} op_e;
  typedef struct {
    op_e op;
    int  arg;
    int  exp_val;
    int  exp_wraps;
  } vec_t;

  vec_t vq[$];

  task automatic apply(input vec_t v);
    case (v.op)
      OP_UP: begin
        drive(0, 1, 8);
        drive(1, 1, 8);
      end
      OP_DN: begin
        drive(1, 0, 8);
        drive(1, 1, 8);
      end
      OP_BOTH: begin
        drive(0, 0, 8);
        drive(1, 1, 8);
      end
      OP_LOAD: begin
        set_sw(4'(v.arg));
        bus.V_SW_LOAD = 1'b1;
        drive(1, 1, 4);
        bus.V_SW_LOAD = 1'b0;
        drive(1, 1, 4);
      end
      default: begin
        set_sw(4'(v.arg));
        bus.V_SW_LOAD = 1'b1;
        drive(1, 1, 3);
        drive(0, 1, 8);
        drive(1, 1, 8);
        bus.V_SW_LOAD = 1'b0;
        drive(1, 1, 4);
      end
    endcase
  endtask

  initial begin
    for (int i = 1; i <= 10; i++)
      vq.push_back('{OP_UP, 0, i, 0});
    vq.push_back('{OP_LOAD, 7, 7, 0});
    for (int i = 8; i <= 99; i++)
      vq.push_back('{OP_UP, 0, i, 0});
    vq.push_back('{OP_UP, 0, 0, 1});
    vq.push_back('{OP_DN, 0, 99, 1});
    vq.push_back('{OP_DN, 0, 98, 0});
    vq.push_back('{OP_BOTH, 0, 98, 0});
    vq.push_back('{OP_LOAD, 12, 98, 0});
    vq.push_back('{OP_LOAD_UP, 5, 5, 0});

    bus.V_KEY_UP  = 1'b1;
    bus.V_KEY_DN  = 1'b1;
    bus.V_SW_LOAD = 1'b0;
    set_sw(4'd0);
    model_reset();
    m_hold = 2;
    repeat (3) cycle();
    check("reset_val", shown(), 0);
    check("reset_wrap", int'(bus.G_WRAP), 0);
    rst_n = 1'b1;
    drive(1, 1, 4);

    foreach (vq[i]) begin
      wrap_seen = 0;
      apply(vq[i]);
      check($sformatf("vec%0d_val", i), shown(), vq[i].exp_val);
      check($sformatf("vec%0d_wraps", i), wrap_seen,
            vq[i].exp_wraps);
    end

    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 3);
      drive(1, 1, 1);
    end
    drive(0, 1, 4);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 3);
      drive(0, 1, 1);
    end
    drive(1, 1, 12);
    check("bounce_val", shown(), 6);

    drive(0, 1, 4);
    async_reset("rst_arming");
    drive(0, 1, 2);
    bus.V_KEY_UP = 1'b1;
    rst_n = 1'b1;
    drive(1, 1, 12);
    check("rst_arming_lost", shown(), 0);

    apply('{OP_LOAD, 3, 3, 0});
    drive(0, 1, 9);
    check("pre_held_val", shown(), 4);
    async_reset("rst_held");
    drive(0, 1, 3);
    rst_n = 1'b1;
    wrap_seen = 0;
    drive(0, 1, 14);
    drive(1, 1, 10);
    check("held_thru_rst", shown(), 1);
    check("held_thru_wraps", wrap_seen, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0)
        bus.V_KEY_UP = ~bus.V_KEY_UP;
      if ($urandom_range(0, 4) == 0)
        bus.V_KEY_DN = ~bus.V_KEY_DN;
      if (bus.V_SW_LOAD) begin
        if ($urandom_range(0, 7) == 0) bus.V_SW_LOAD = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        bus.V_SW_LOAD = 1'b1;
      end
      if ($urandom_range(0, 7) == 0)
        set_sw(4'($urandom_range(0, 15)));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
